// File: rtl/pe_array_pkg.sv
// Shared constants for the PE array and its result collector.
package pe_array_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    // Requantized results are clamped to a signed 8-bit range
    localparam int QMIN = -128;
    localparam int QMAX = 127;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. No bypass: read data is always the registered head entry.
// A read on an empty FIFO is ignored. A write on a full FIFO is accepted only
// when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks writes minus reads
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Collects skewed partial sums from the systolic array, realigns them into
// rows, optionally requantizes to int8 range, and buffers rows in a FIFO.
// Latency from in_valid to out_valid is COLS+1 cycles into an empty FIFO.
module psum_collector
    import pe_array_pkg::*;
#(
    parameter int ACC_WIDTH  = pe_array_pkg::ACC_WIDTH,
    parameter int COLS       = pe_array_pkg::COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [ACC_WIDTH*COLS-1:0]          psum_in_flat,
    input  logic                               quantize_mode,
    input  logic [4:0]                         shift,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_WIDTH*COLS-1:0]          row_out_flat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow
);

    localparam int VD = (COLS > 1) ? COLS - 1 : 1;
    localparam logic signed [ACC_WIDTH-1:0] QMAX_W = ACC_WIDTH'(QMAX);
    localparam logic signed [ACC_WIDTH-1:0] QMIN_W = ACC_WIDTH'(QMIN);

    logic [COLS-1:0][ACC_WIDTH-1:0] aligned;
    logic                           aligned_vld;
    logic [VD-1:0]                  vld_pipe;
    logic [COLS-1:0][ACC_WIDTH-1:0] q_next;
    logic [COLS-1:0][ACC_WIDTH-1:0] q_data;
    logic                           q_vld;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic                           fifo_full;
    logic                           fifo_empty;

    // Column c arrives c cycles late, so it is delayed by COLS-1-c to line up with the last column
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign aligned[c] = psum_in_flat[c*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dly [D];
            // Per-column deskew delay line (data only, not reset)
            always_ff @(posedge clk) begin
                dly[0] <= psum_in_flat[c*ACC_WIDTH +: ACC_WIDTH];
                for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
            end
            assign aligned[c] = dly[D-1];
        end
    end

    // Row valid follows column 0 through the same COLS-1 stages
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= (vld_pipe << 1) | VD'(in_valid);
    end

    if (COLS > 1) begin : g_vld
        assign aligned_vld = vld_pipe[VD-1];
    end else begin : g_vld0
        assign aligned_vld = in_valid;
    end

    // Requantize: arithmetic shift then clamp to int8, sign-extended back to ACC_WIDTH
    always_comb begin
        q_next  = aligned;
        shifted = '0;
        if (quantize_mode) begin
            for (int c = 0; c < COLS; c++) begin
                shifted = $signed(aligned[c]) >>> shift;
                if (shifted > QMAX_W)      q_next[c] = QMAX_W;
                else if (shifted < QMIN_W) q_next[c] = QMIN_W;
                else                       q_next[c] = shifted;
            end
        end
    end

    // Quantize stage register; only the valid bit is reset
    always_ff @(posedge clk) begin
        if (rst) q_vld <= 1'b0;
        else     q_vld <= aligned_vld;
        q_data <= q_next;
    end

    sync_fifo #(
        .WIDTH (ACC_WIDTH*COLS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (q_vld),
        .wr_data (q_data),
        .rd_en   (out_ready),
        .rd_data (row_out_flat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = !fifo_empty;

    // Sticky drop flag: a row hit a full FIFO that was not draining that cycle
    always_ff @(posedge clk) begin
        if (rst)                                  overflow <= 1'b0;
        else if (q_vld && fifo_full && !out_ready) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_psum_collector.sv
// Randomized + directed bench for psum_collector with a queue-based scoreboard.
module tb_psum_collector;

    localparam int W  = 32;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    typedef logic [C-1:0][W-1:0] row_t;
    typedef struct { int due; row_t row; } fl_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          quantize_mode = 1'b0;
    logic [4:0]    shift = '0;
    logic          out_ready = 1'b0;
    row_t          psum_in = '0;
    logic          out_valid;
    row_t          row_out;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    psum_collector #(.ACC_WIDTH(W), .COLS(C), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .psum_in_flat  (psum_in),
        .quantize_mode (quantize_mode),
        .shift         (shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .row_out_flat  (row_out),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   checking = 0;
    bit   hist_v [8];
    row_t hist_d [8];
    fl_t  fl_q [$];
    row_t exp_q [$];
    bit   ovf_m = 0;

    // Reference requantization from the arithmetic definition
    function automatic logic [W-1:0] qexp(input int v, input bit mode, input int sh);
        longint s;
        if (!mode) return v;
        s = longint'(v) >>> sh;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return W'(s);
    endfunction

    function automatic row_t qrow(input row_t r);
        row_t o;
        for (int c = 0; c < C; c++) o[c] = qexp(int'(r[c]), quantize_mode, int'(shift));
        return o;
    endfunction

    function automatic row_t mk(input int a, input int b, input int c2, input int d);
        row_t r;
        r[0] = a; r[1] = b; r[2] = c2; r[3] = d;
        return r;
    endfunction

    function automatic int rval();
        case ($urandom % 3)
            0:       return int'($urandom_range(0, 400)) - 200;
            1:       return int'($urandom_range(0, 4000)) - 2000;
            default: return int'($urandom);
        endcase
    endfunction

    function automatic row_t rrow();
        row_t r;
        for (int c = 0; c < C; c++) r[c] = rval();
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // One cycle of stimulus: row columns are presented with the array's skew
    task automatic tick(input bit v, input row_t r, input bit rdy, input bit rs = 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        hist_v[cyc % 8] = v;
        hist_d[cyc % 8] = r;
        in_valid  = v;
        out_ready = rdy;
        rst       = rs;
        for (int c = 0; c < C; c++) begin
            if (cyc - c > 0 && hist_v[(cyc - c) % 8]) psum_in[c] = hist_d[(cyc - c) % 8][c];
            else                                       psum_in[c] = $urandom;
        end
        if (v && !rs) fl_q.push_back('{cyc + 4, qrow(r)});
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(1'b0, '0, rdy);
    endtask

    // Monitor + model: compare visible state, then advance the model across the coming edge
    int  sz;
    bit  rd;
    fl_t f;
    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            chk("fifo_count", 128'(fifo_count), 128'(exp_q.size()));
            chk("overflow", 128'(overflow), 128'(ovf_m));
            if (out_valid && exp_q.size() > 0) chk("row", 128'(row_out), 128'(exp_q[0]));
            if (rst) begin
                fl_q.delete();
                exp_q.delete();
                ovf_m = 0;
            end else begin
                sz = exp_q.size();
                rd = (sz > 0) && out_ready;
                if (rd) void'(exp_q.pop_front());
                if (fl_q.size() > 0 && fl_q[0].due == cyc) begin
                    f = fl_q.pop_front();
                    if (sz == D && !rd) ovf_m = 1;
                    else                exp_q.push_back(f.row);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) hist_v[i] = 0;
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);
        checking = 1;
        idle(2, 1'b1);

        // Single row, passthrough
        tick(1'b1, mk(140, 141, 142, 143), 1'b1);
        idle(8, 1'b1);

        // Eight back-to-back rows, always ready
        for (int i = 0; i < 8; i++) tick(1'b1, rrow(), 1'b1);
        idle(8, 1'b1);

        // Backpressure: five rows into a four-deep FIFO, then drain
        for (int i = 0; i < 5; i++) tick(1'b1, rrow(), 1'b0);
        idle(6, 1'b0);
        idle(8, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Full FIFO with a read and a write in the same cycle
        for (int i = 0; i < 5; i++) tick(1'b1, rrow(), 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Requantization corner values
        quantize_mode = 1'b1; shift = 5'd2;
        tick(1'b1, mk(1000, -1000, 300, -7), 1'b1);
        idle(6, 1'b1);
        shift = 5'd1;
        tick(1'b1, mk(-7, 5, -300, 256), 1'b1);
        idle(6, 1'b1);
        shift = 5'd0;
        tick(1'b1, mk(127, 128, -128, -129), 1'b1);
        idle(6, 1'b1);
        quantize_mode = 1'b0;
        tick(1'b1, mk(1000, -1000, 300, -7), 1'b1);
        idle(6, 1'b1);

        // Reset with two rows buffered and one in flight
        tick(1'b1, rrow(), 1'b0);
        tick(1'b1, rrow(), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b1, rrow(), 1'b0);
        idle(2, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        idle(10, 1'b1);

        // Random traffic in batches with static mode/shift per batch
        for (int b = 0; b < 8; b++) begin
            quantize_mode = 1'($urandom % 2);
            shift = 5'($urandom % 12);
            for (int i = 0; i < 40; i++)
                tick(($urandom % 3) != 0, rrow(), (b % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 3) == 0));
            idle(12, 1'b1);
            tick(1'b0, '0, 1'b1, 1'b1);
            idle(2, 1'b1);
        end

        chk("drained", 128'(exp_q.size() + fl_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
